// File: rtl/agc_pkg.sv
// Shared constants and helpers for the AGC timing blocks (timer, scaler).
package agc_pkg;

    localparam int SCALER_STAGES      = 16;
    localparam int SCALER_FIRST_STAGE = 2;
    localparam int SCALER_ALARM_LIMIT = 2048;

    typedef logic [SCALER_STAGES-1:0] scaler_word_t;

    // Rise strobes for one increment. On wrap to zero no bit rises, but
    // consumers still expect one rise per count, so FS02 is reported.
    function automatic scaler_word_t rise_strobe(scaler_word_t old_v, scaler_word_t new_v);
        if (new_v == '0)
            return scaler_word_t'(1);
        return ~old_v & new_v;
    endfunction

endpackage

// File: rtl/scaler_watchdog.sv
// Scaler-fail watchdog: counts SIM_CLK cycles since the last FS01 edge and
// flags an alarm once the count saturates at LIMIT.
module scaler_watchdog
    import agc_pkg::*;
#(
    parameter int LIMIT = SCALER_ALARM_LIMIT,
    parameter int WIDTH = 12
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic fs_edge,
    output logic alarm
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] wd_q;
    logic [WIDTH-1:0] wd_d;

    always_comb begin
        wd_d = wd_q;
        if (fs_edge)
            wd_d = '0;
        else if (wd_q != LIM)
            wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end

    assign alarm = (wd_q == LIM);

endmodule

// File: rtl/a1_scaler.sv
// 16-stage binary scaler driven by the timer's FS01 wave, with per-stage
// rise/fall strobes. Watchdog alarm built only with SCALER_FAIL_ALARM_EN.
module a1_scaler
    import agc_pkg::*;
#(
    parameter int ALARM_LIMIT = SCALER_ALARM_LIMIT,
    parameter int WD_WIDTH    = 12
) (
    input  logic                     SIM_CLK,
    input  logic                     SIM_RST,
    input  logic                     FS01,
    input  logic                     HOLD,
    output logic [SCALER_STAGES-1:0] FS,
    output logic [SCALER_STAGES-1:0] FA,
    output logic [SCALER_STAGES-1:0] FB,
    output logic                     SCAFAL
);

    if (WD_WIDTH < 1 || WD_WIDTH > 30 || (2 ** WD_WIDTH) <= ALARM_LIMIT
        || SCALER_FIRST_STAGE + SCALER_STAGES - 1 != 17) begin : g_cfg_err
        $error("a1_scaler: WD_WIDTH too narrow for ALARM_LIMIT or bad stage map");
    end

    logic         fs01_q;
    logic         fs01_fall;
    logic         inc;
    scaler_word_t cnt_q, cnt_d;
    scaler_word_t fa_q, fa_d;
    scaler_word_t fb_q, fb_d;

    assign fs01_fall = fs01_q & ~FS01;
    // A falling edge seen under HOLD is dropped, not deferred.
    assign inc       = fs01_fall & ~HOLD;

    always_comb begin
        cnt_d = cnt_q;
        fa_d  = '0;
        fb_d  = '0;
        if (inc) begin
            cnt_d = cnt_q + 1'b1;
            fa_d  = rise_strobe(cnt_q, cnt_d);
            fb_d  = cnt_q & ~cnt_d;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            fs01_q <= 1'b0;
            cnt_q  <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
        end else begin
            fs01_q <= FS01;
            cnt_q  <= cnt_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
        end
    end

    assign FS = cnt_q;
    assign FA = fa_q;
    assign FB = fb_q;

`ifdef SCALER_FAIL_ALARM_EN
    logic fs01_edge;
    assign fs01_edge = fs01_q ^ FS01;

    scaler_watchdog #(
        .LIMIT (ALARM_LIMIT),
        .WIDTH (WD_WIDTH)
    ) u_wd (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .fs_edge (fs01_edge),
        .alarm   (SCAFAL)
    );
`else
    assign SCAFAL = 1'b0;
`endif

endmodule

// File: tb/tb_a1_scaler.sv
// Scoreboard bench for a1_scaler: driver pushes model expectations per cycle,
// monitor pops and compares after each rising clock edge.
module tb_a1_scaler;

    localparam int LIM = 16;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b1;
    logic        FS01    = 1'b0;
    logic        HOLD    = 1'b0;
    logic [15:0] FS, FA, FB;
    logic        SCAFAL;

    a1_scaler #(.ALARM_LIMIT(LIM), .WD_WIDTH(5)) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .FS01    (FS01),
        .HOLD    (HOLD),
        .FS      (FS),
        .FA      (FA),
        .FB      (FB),
        .SCAFAL  (SCAFAL)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    typedef struct {
        bit [15:0] fs;
        bit [15:0] fa;
        bit [15:0] fb;
        bit        scafal;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: integer count, previous FS01 level, silence counter.
    bit [15:0] m_cnt  = 0;
    bit        m_prev = 0;
    int        m_wd   = 0;
`ifdef SCALER_FAIL_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    always begin
        exp_t e;
        @(posedge SIM_CLK);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("FS", FS, e.fs);
            chk("FA", FA, e.fa);
            chk("FB", FB, e.fb);
            chk("SCAFAL", {15'd0, SCAFAL}, {15'd0, e.scafal});
        end
    end

    task automatic step(input bit f, input bit h, input bit r);
        exp_t e;
        bit   fall, rise;
        int   t;
        @(negedge SIM_CLK);
        FS01 = f; HOLD = h; SIM_RST = r;
        e.fa = 0; e.fb = 0;
        if (r) begin
            m_cnt = 0; m_prev = 0; m_wd = 0;
        end else begin
            fall = m_prev && !f;
            rise = !m_prev && f;
            if (fall && !h) begin
                t = 0;
                while (t < 16 && m_cnt[t]) t++;
                e.fb  = (t == 16) ? 16'hFFFF : 16'((1 << t) - 1);
                e.fa  = (t == 16) ? 16'h0001 : 16'(1 << t);
                m_cnt = m_cnt + 16'd1;
            end
            if (fall || rise) m_wd = 0;
            else if (m_wd < LIM) m_wd++;
            m_prev = f;
        end
        e.fs     = m_cnt;
        e.scafal = ALARM_EN && (m_wd == LIM);
        q.push_back(e);
    endtask

    task automatic edges(input int n, input int half, input bit h);
        for (int i = 0; i < n; i++) begin
            repeat (half) step(1, h, 0);
            repeat (half) step(0, h, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with FS01 toggling
        for (int i = 0; i < 3; i++) step(i[0], 0, 1);
        step(0, 0, 1);
        // Five falling edges, 4-cycle period
        edges(5, 2, 0);
        // HOLD across three falling edges, release, then one more edge
        edges(3, 2, 1);
        step(0, 0, 0);
        edges(1, 2, 0);
        // Silence past the watchdog limit, then a single rising edge
        repeat (20) step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        // Random FS01/HOLD
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 97) == 0);
        // Count to 0x1234, then reset coincident with a falling edge
        step(0, 0, 1);
        edges(16'h1234, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        edges(3, 1, 0);
        // Wrap: backdoor preload to 0xFFFF, then one falling edge
        step(1, 0, 0);
        @(posedge SIM_CLK);
        #2;
        dut.cnt_q <= 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        edges(2, 1, 0);
        // Drain the scoreboard
        repeat (3) @(posedge SIM_CLK);
        #2;
        chk("drain", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
